// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the fetch unit and the control_block decoder.
//   OPCODE_W      opcode field width
//   OP_NOP        opcode the decoder treats as "no write, no memory access"
//   TIMEOUT_LIMIT FETCH cycles without imem_ack before the optional timeout fires
//   ifu_state_e   fetch unit FSM states
package cpu_pkg;

    localparam int unsigned OPCODE_W = 4;
    localparam logic [OPCODE_W-1:0] OP_NOP = 4'hF;
    localparam int unsigned TIMEOUT_LIMIT = 15;

    typedef enum logic [1:0] {
        StRst,
        StFetch,
        StIssue
    } ifu_state_e;

endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with hold / increment / redirect select.
//   clk, rst_n  clock, asynchronous active-low reset (pc returns to RESET_PC)
//   advance     update pc this cycle; otherwise hold
//   redirect    when advancing, load target instead of pc+1
//   target      redirect address
//   pc          current program counter
// The increment wraps modulo 2^ADDR_W.
module pc_reg #(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              advance,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    output logic [ADDR_W-1:0] pc
);

    logic [ADDR_W-1:0] pc_d, pc_q;

    always_comb begin
        pc_d = pc_q;
        if (advance) begin
            pc_d = redirect ? target : pc_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= ADDR_W'(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches one instruction at a time and issues its opcode downstream.
//   clk, rst_n     clock, asynchronous active-low reset
//   imem_req       fetch request (registered), imem_addr = pc
//   imem_ack       memory response valid, only looked at in FETCH
//   imem_rdata     instruction word returned with imem_ack
//   stall          downstream not ready, holds the issued instruction
//   branch_taken   redirect request, taken with a non-stalled issue
//   branch_target  redirect address
//   pc             address of the held instruction
//   instr          instruction register
//   opcode         instr opcode field, OP_NOP when nothing valid is held
//   instr_valid    instr/opcode hold a real instruction
//   fetch_err      sticky fetch timeout flag
// Compile option: define IFU_TIMEOUT_EN to abandon a fetch after TIMEOUT_LIMIT cycles
// without imem_ack; the unit then issues a NOP and sets fetch_err. Without it fetch_err is 0.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned INSTR_W  = 16,
    parameter int unsigned RESET_PC = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic [INSTR_W-1:0] instr,
    output logic [OPCODE_W-1:0] opcode,
    output logic               instr_valid,
    output logic               fetch_err
);

    ifu_state_e         state_q;
    logic               imem_req_q;
    logic               instr_valid_q;
    logic [INSTR_W-1:0] instr_q;
    logic               pc_advance;
    logic               timeout_hit;

    // The pc moves only on the issue handshake; stall wins over a pending redirect.
    assign pc_advance = (state_q == StIssue) && !stall;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .advance  (pc_advance),
        .redirect (branch_taken),
        .target   (branch_target),
        .pc       (pc)
    );

`ifdef IFU_TIMEOUT_EN
    logic [3:0] tmo_cnt_q;
    logic       fetch_err_q;

    assign timeout_hit = (state_q == StFetch) && !imem_ack &&
                         (tmo_cnt_q == 4'(TIMEOUT_LIMIT - 1));

    // Counts FETCH cycles without ack; held at zero outside FETCH so each fetch starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q   <= 4'd0;
            fetch_err_q <= 1'b0;
        end else begin
            if (state_q != StFetch || imem_ack || timeout_hit) begin
                tmo_cnt_q <= 4'd0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 4'd1;
            end
            if (timeout_hit) begin
                fetch_err_q <= 1'b1;
            end
        end
    end

    assign fetch_err = fetch_err_q;
`else
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StRst;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_q       <= '0;
        end else begin
            case (state_q)
                StRst: begin
                    state_q    <= StFetch;
                    imem_req_q <= 1'b1;
                end
                StFetch: begin
                    if (imem_ack) begin
                        instr_q       <= imem_rdata;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= StIssue;
                    end else if (timeout_hit) begin
                        // Abandoned fetch is issued as a NOP so the pipeline keeps moving.
                        instr_q       <= {OP_NOP, {(INSTR_W - OPCODE_W){1'b0}}};
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    if (!stall) begin
                        instr_valid_q <= 1'b0;
                        imem_req_q    <= 1'b1;
                        state_q       <= StFetch;
                    end
                end
                default: begin
                    state_q    <= StRst;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign opcode      = instr_valid_q ? instr_q[INSTR_W-1 -: OPCODE_W] : OP_NOP;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = '0;
    logic [7:0]  pc;
    logic [15:0] instr;
    logic [3:0]  opcode;
    logic        instr_valid;
    logic        fetch_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W   (8),
        .INSTR_W  (16),
        .RESET_PC (0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (pc),
        .instr         (instr),
        .opcode        (opcode),
        .instr_valid   (instr_valid),
        .fetch_err     (fetch_err)
    );

    typedef struct {
        logic        ack;
        logic [15:0] rdata;
        logic        stl;
        logic        br;
        logic [7:0]  tgt;
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_valid;
        logic [3:0]  e_op;
        logic [15:0] e_instr;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic row(input logic ack, input logic [15:0] rdata, input logic stl,
                       input logic br, input logic [7:0] tgt, input logic e_req,
                       input logic [7:0] e_addr, input logic e_valid, input logic [3:0] e_op,
                       input logic [15:0] e_instr);
        vec_t v;
        v.ack = ack; v.rdata = rdata; v.stl = stl; v.br = br; v.tgt = tgt;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_op = e_op;
        v.e_instr = e_instr;
        tbl.push_back(v);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " req"},   32'(imem_req), 32'd0);
        check({tag, " valid"}, 32'(instr_valid), 32'd0);
        check({tag, " op"},    32'(opcode), 32'hF);
        check({tag, " pc"},    32'(pc), 32'd0);
        check({tag, " addr"},  32'(imem_addr), 32'd0);
        check({tag, " instr"}, 32'(instr), 32'd0);
        check({tag, " err"},   32'(fetch_err), 32'd0);
    endtask

    // Watchdog: the bench must always reach its summary.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       exp_req, exp_valid, first;
        logic [7:0] exp_pc;
        logic [15:0] exp_instr;
        int         wait_cnt;

        // Directed table: inputs applied at each negedge after the expected outputs are checked.
        //  ack rdata   stl br tgt    req addr  v  op    instr
        row(1, 16'h2000, 0, 0, 8'h00, 1, 8'h00, 0, 4'hF, 16'h0000);
        row(0, 16'h0000, 0, 0, 8'h00, 0, 8'h00, 1, 4'h2, 16'h2000);
        row(1, 16'h0123, 0, 0, 8'h00, 1, 8'h01, 0, 4'hF, 16'h2000);
        row(1, 16'hDEAD, 1, 0, 8'h00, 0, 8'h01, 1, 4'h0, 16'h0123);
        row(0, 16'h0000, 1, 0, 8'h00, 0, 8'h01, 1, 4'h0, 16'h0123);
        row(0, 16'h0000, 1, 0, 8'h00, 0, 8'h01, 1, 4'h0, 16'h0123);
        row(0, 16'h0000, 1, 0, 8'h00, 0, 8'h01, 1, 4'h0, 16'h0123);
        row(0, 16'h0000, 1, 0, 8'h00, 0, 8'h01, 1, 4'h0, 16'h0123);
        row(0, 16'h0000, 0, 0, 8'h00, 0, 8'h01, 1, 4'h0, 16'h0123);
        row(1, 16'h5ABC, 0, 0, 8'h00, 1, 8'h02, 0, 4'hF, 16'h0123);
        row(0, 16'h0000, 1, 1, 8'h40, 0, 8'h02, 1, 4'h5, 16'h5ABC);
        row(0, 16'h0000, 0, 1, 8'h40, 0, 8'h02, 1, 4'h5, 16'h5ABC);
        row(0, 16'h0000, 1, 1, 8'h77, 1, 8'h40, 0, 4'hF, 16'h5ABC);
        row(1, 16'hFFFF, 0, 0, 8'h00, 1, 8'h40, 0, 4'hF, 16'h5ABC);
        row(0, 16'h0000, 0, 1, 8'hFF, 0, 8'h40, 1, 4'hF, 16'hFFFF);
        row(1, 16'h1111, 0, 0, 8'h00, 1, 8'hFF, 0, 4'hF, 16'hFFFF);
        row(0, 16'h0000, 0, 0, 8'h00, 0, 8'hFF, 1, 4'h1, 16'h1111);
        row(0, 16'h0000, 0, 0, 8'h00, 1, 8'h00, 0, 4'hF, 16'h1111);

        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            @(negedge clk);
            check($sformatf("row%0d req", i),   32'(imem_req), 32'(tbl[i].e_req));
            check($sformatf("row%0d addr", i),  32'(imem_addr), 32'(tbl[i].e_addr));
            check($sformatf("row%0d pc", i),    32'(pc), 32'(tbl[i].e_addr));
            check($sformatf("row%0d valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            check($sformatf("row%0d op", i),    32'(opcode), 32'(tbl[i].e_op));
            check($sformatf("row%0d instr", i), 32'(instr), 32'(tbl[i].e_instr));
            imem_ack      = tbl[i].ack;
            imem_rdata    = tbl[i].rdata;
            stall         = tbl[i].stl;
            branch_taken  = tbl[i].br;
            branch_target = tbl[i].tgt;
        end

        // Reset asserted mid-fetch, away from any clock edge: outputs drop at once.
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_rst");
        imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;

        // Randomized run against a transaction-level model of the fetch/issue rules.
        @(negedge clk);
        rst_n     = 1'b1;
        first     = 1'b1;
        exp_req   = 1'b0;
        exp_valid = 1'b0;
        exp_pc    = 8'h00;
        exp_instr = 16'h0000;
        wait_cnt  = 0;
        for (int c = 0; c < 1500; c++) begin
            if (c != 0) @(negedge clk);
            check("rnd req",   32'(imem_req), 32'(exp_req));
            check("rnd valid", 32'(instr_valid), 32'(exp_valid));
            check("rnd pc",    32'(imem_addr), 32'(exp_pc));
            check("rnd instr", 32'(instr), 32'(exp_instr));
            check("rnd op",    32'(opcode), exp_valid ? 32'(exp_instr[15:12]) : 32'hF);
            check("rnd err",   32'(fetch_err), 32'd0);

            imem_ack      = ($urandom_range(2) == 0) || (wait_cnt >= 8);
            imem_rdata    = 16'($urandom);
            stall         = ($urandom_range(2) == 0);
            branch_taken  = ($urandom_range(3) == 0);
            branch_target = 8'($urandom);

            if (first) begin
                first   = 1'b0;
                exp_req = 1'b1;
            end else if (exp_req) begin
                if (imem_ack) begin
                    exp_instr = imem_rdata;
                    exp_req   = 1'b0;
                    exp_valid = 1'b1;
                    wait_cnt  = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (exp_valid && !stall) begin
                exp_pc    = branch_taken ? branch_target : 8'((int'(exp_pc) + 1) % 256);
                exp_valid = 1'b0;
                exp_req   = 1'b1;
            end
        end

`ifdef IFU_TIMEOUT_EN
        // Withhold ack: after 15 FETCH cycles a NOP issues and fetch_err sticks.
        @(negedge clk);
        rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check($sformatf("tmo wait%0d req", k), 32'(imem_req), 32'd1);
        end
        @(negedge clk);
        check("tmo req",   32'(imem_req), 32'd0);
        check("tmo valid", 32'(instr_valid), 32'd1);
        check("tmo op",    32'(opcode), 32'hF);
        check("tmo instr", 32'(instr), 32'hF000);
        check("tmo err",   32'(fetch_err), 32'd1);
        @(negedge clk);
        check("tmo next addr", 32'(imem_addr), 32'd1);
        check("tmo next req",  32'(imem_req), 32'd1);
        check("tmo err sticky", 32'(fetch_err), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
